// File: rtl/bank_group_burst_ctrl.sv
// Per-bank-group burst controller: requests the arbiter, then issues a same-direction
// burst from the group's bank queues, choosing banks round-robin, and pulses done when finished.
module bank_group_burst_ctrl #(
  parameter int NUM_BANKS   = 4,
  parameter int MAX_BURST   = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANKS-1:0]         bank_valid,
  input  logic [NUM_BANKS-1:0]         bank_rd,
  input  logic                         start,
  input  logic                         issue_ready,
  output logic                         req,
  output logic                         done,
  output logic                         issue_valid,
  output logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  output logic [NUM_BANKS-1:0]         pop,
  output logic                         burst_rd
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   rr_ptr, rr_next;
  logic [CW-1:0]   cnt, cnt_next, cnt_inc;
  logic [SW-1:0]   stall, stall_next, stall_inc;
  logic            burst_rd_next;
  logic [NUM_BANKS-1:0] eligible;
  logic [BW:0]     pick_hit;
  logic [BW:0]     first_hit;

  // Returns {hit, index} of the first set bit at or after base, wrapping around.
  function automatic logic [BW:0] rr_find(input logic [NUM_BANKS-1:0] mask,
                                          input logic [BW-1:0]        base);
    logic [BW-1:0] idx;
    rr_find = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      idx = base + BW'(i);
      if (mask[idx]) rr_find = {1'b1, idx};
    end
  endfunction

  assign req       = |bank_valid;
  assign eligible  = bank_valid & ~(bank_rd ^ {NUM_BANKS{burst_rd}});
  assign pick_hit  = rr_find(eligible, rr_ptr);
  assign first_hit = rr_find(bank_valid, rr_ptr);
  assign cnt_inc   = cnt + 1'b1;
  assign stall_inc = stall + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      stall    <= '0;
      burst_rd <= 1'b1;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_next;
      cnt      <= cnt_next;
      stall    <= stall_next;
      burst_rd <= burst_rd_next;
    end
  end

  always_comb begin
    state_next    = state;
    rr_next       = rr_ptr;
    cnt_next      = cnt;
    stall_next    = stall;
    burst_rd_next = burst_rd;
    issue_valid   = 1'b0;
    bank_sel      = '0;
    pop           = '0;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (first_hit[BW]) begin
            burst_rd_next = bank_rd[first_hit[BW-1:0]];
            cnt_next      = '0;
            stall_next    = '0;
            state_next    = BURST;
          end else begin
            state_next = DONE;
          end
        end
      end
      BURST: begin
        if (!start) begin
          state_next = IDLE;
        end else if (!pick_hit[BW]) begin
          state_next = DONE;
        end else begin
          issue_valid = 1'b1;
          bank_sel    = pick_hit[BW-1:0];
          if (issue_ready) begin
            pop[pick_hit[BW-1:0]] = 1'b1;
            rr_next    = pick_hit[BW-1:0] + 1'b1;
            stall_next = '0;
            if (cnt != CW'(MAX_BURST)) cnt_next = cnt_inc;
            if (cnt_inc == CW'(MAX_BURST)) state_next = DONE;
          end else begin
            if (stall != SW'(STALL_LIMIT)) stall_next = stall_inc;
            if (stall_inc == SW'(STALL_LIMIT)) state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
